// File: rtl/vgactl_pkg.sv
// Shared constants and types for the VGA controller: 640x480@60 timing,
// the 320x240 RGB332 framebuffer geometry and the graphics-memory widths.
package vgactl_pkg;

  localparam int GMEM_WIDTH  = 17;
  localparam int COLOR_WIDTH = 8;
  localparam int CNT_WIDTH   = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;

  localparam int RGB_R_HI = 7;
  localparam int RGB_R_LO = 5;
  localparam int RGB_G_HI = 4;
  localparam int RGB_G_LO = 2;
  localparam int RGB_B_HI = 1;
  localparam int RGB_B_LO = 0;

  typedef logic [CNT_WIDTH-1:0]   cnt_t;
  typedef logic [GMEM_WIDTH-1:0]  gaddr_t;
  typedef logic [COLOR_WIDTH-1:0] rgb_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vgactl_timing.sv
// Pixel-clock divider, horizontal/vertical counters and sync decode.
// Everything is held cleared while the display is disabled so a rising
// enable always restarts the frame at (0,0).
module vga_timing
  import vgactl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output cnt_t hcnt,
  output cnt_t vcnt,
  output logic active,
  output logic hs,
  output logic vs
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;

  assign tick   = en && (div_q == DIV_LAST);
  assign hcnt   = hcnt_q;
  assign vcnt   = vcnt_q;
  assign active = (hcnt_q < cnt_t'(H_ACTIVE)) && (vcnt_q < cnt_t'(V_ACTIVE));
  assign hs     = !((hcnt_q >= cnt_t'(H_SYNC_START)) && (hcnt_q < cnt_t'(H_SYNC_END)));
  assign vs     = !((vcnt_q >= cnt_t'(V_SYNC_START)) && (vcnt_q < cnt_t'(V_SYNC_END)));

  // Next-state for the divider and the raster position; counters move only on a tick.
  always_comb begin
    div_d  = div_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!en) begin
      div_d  = '0;
      hcnt_d = '0;
      vcnt_d = '0;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (tick) begin
        if (hcnt_q == cnt_t'(H_TOTAL - 1)) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == cnt_t'(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
    end
  end

  // Timing state registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/vgactl.sv
// VGA controller top: issues a 2x-upscaled framebuffer read address on each
// pixel tick, captures the returned RGB332 pixel one tick later and delays
// the sync/enable decode by the same amount so all outputs line up.
module vgactl
  import vgactl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int RD_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [GMEM_WIDTH-1:0]  vgactl_addr,
  input  logic [COLOR_WIDTH-1:0] vgactl_dat,
  output logic [COLOR_WIDTH-1:0] vga_rgb,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_de,
  output logic                   frame_irq
);

  // Read data must settle inside one pixel period and the framebuffer must fit the address space.
  if (CLK_DIV < 3 || RD_LAT >= CLK_DIV || FB_WIDTH * FB_HEIGHT > (1 << GMEM_WIDTH)) begin : g_bad_params
    $error("vgactl: illegal CLK_DIV/RD_LAT/framebuffer combination");
  end

  logic tick, t_active, t_hs, t_vs;
  cnt_t hcnt, vcnt;

  gaddr_t row_base_q, row_base_d;
  gaddr_t addr_q, addr_d;
  rgb_t   rgb_q, rgb_d;
  sync_t  s1_q, s1_d;
  sync_t  out_q, out_d;
  logic   irq_q, irq_d;
  logic   last_col;

  vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .tick   (tick),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .active (t_active),
    .hs     (t_hs),
    .vs     (t_vs)
  );

  assign last_col = (hcnt == cnt_t'(H_TOTAL - 1));

  // Address generation, row-base stepping and the one-pixel output pipeline.
  always_comb begin
    row_base_d = row_base_q;
    addr_d     = addr_q;
    rgb_d      = rgb_q;
    s1_d       = s1_q;
    out_d      = out_q;
    irq_d      = 1'b0;
    if (!en) begin
      row_base_d = '0;
      addr_d     = '0;
      rgb_d      = '0;
      s1_d       = SYNC_IDLE;
      out_d      = SYNC_IDLE;
    end else if (tick) begin
      addr_d = t_active ? row_base_q + gaddr_t'(hcnt[CNT_WIDTH-1:1]) : '0;
      s1_d   = '{de: t_active, hs: t_hs, vs: t_vs};
      out_d  = s1_q;
      rgb_d  = s1_q.de ? {vgactl_dat[RGB_R_HI:RGB_R_LO],
                          vgactl_dat[RGB_G_HI:RGB_G_LO],
                          vgactl_dat[RGB_B_HI:RGB_B_LO]} : '0;
      irq_d  = last_col && (vcnt == cnt_t'(V_ACTIVE - 1));
      if (last_col) begin
        if (vcnt == cnt_t'(V_TOTAL - 1)) begin
          row_base_d = '0;
        end else if (vcnt[0] && (vcnt < cnt_t'(V_ACTIVE))) begin
          row_base_d = row_base_q + gaddr_t'(FB_WIDTH);
        end
      end
    end
  end

  // Pipeline and address registers; reset lands on the idle output values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_base_q <= '0;
      addr_q     <= '0;
      rgb_q      <= '0;
      s1_q       <= SYNC_IDLE;
      out_q      <= SYNC_IDLE;
      irq_q      <= 1'b0;
    end else begin
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      rgb_q      <= rgb_d;
      s1_q       <= s1_d;
      out_q      <= out_d;
      irq_q      <= irq_d;
    end
  end

  assign vgactl_addr = addr_q;
  assign vga_rgb     = rgb_q;
  assign vga_de      = out_q.de;
  assign vga_hs      = out_q.hs;
  assign vga_vs      = out_q.vs;
  assign frame_irq   = irq_q;

endmodule

// File: tb/tb_vgactl.sv
// Self-checking bench for vgactl: graphics-memory model with a two-clock
// read latency, scenario tasks with inline checks, and a pixel scoreboard.
module tb_vgactl;

  localparam int CLK_DIV = 4;
  localparam int RD_LAT  = 2;
  localparam logic [28:0] IDLE = {17'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [16:0] vgactl_addr;
  logic [7:0]  vgactl_dat;
  logic [7:0]  vga_rgb;
  logic        vga_hs, vga_vs, vga_de, frame_irq;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  logic [7:0]  exp_q[$];
  logic [16:0] a1 = '0;
  logic [16:0] a2 = '0;
  logic [9:0]  f_h, f_v;
  logic [16:0] f_rb;

  vgactl #(.CLK_DIV(CLK_DIV), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .vgactl_addr (vgactl_addr),
    .vgactl_dat  (vgactl_dat),
    .vga_rgb     (vga_rgb),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_de      (vga_de),
    .frame_irq   (frame_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmem(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'h2d, a[16]};
  endfunction

  // Graphics memory: data for an address appears two clocks after it is presented.
  always @(posedge clk) begin
    a1 <= vgactl_addr;
    a2 <= a1;
  end
  assign vgactl_dat = gmem(a2);

  function automatic logic [28:0] outs();
    return {vgactl_addr, vga_rgb, vga_de, vga_hs, vga_vs, frame_irq};
  endfunction

  task automatic to_edge(input int n);
    repeat (n - edges) @(posedge clk);
    if (n > edges) edges = n;
    #1;
  endtask

  task automatic to_tick(input int k);
    to_edge(CLK_DIV * k);
  endtask

  task automatic en_rise();
    @(negedge clk) en = 1'b0;
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1;
    edges = 1;
  endtask

  task start_at(input logic [9:0] h, input logic [9:0] v, input logic [16:0] rb);
    f_h = h; f_v = v; f_rb = rb;
    @(negedge clk) en = 1'b0;
    @(negedge clk) en = 1'b1;
    force dut.u_timing.hcnt_q = f_h;
    force dut.u_timing.vcnt_q = f_v;
    force dut.row_base_q = f_rb;
    @(posedge clk);
    #1;
    release dut.u_timing.hcnt_q;
    release dut.u_timing.vcnt_q;
    release dut.row_base_q;
    edges = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs() !== IDLE) begin errors++; $display("[TB] FAIL reset_idle got=%h want=%h", outs(), IDLE); end
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outs() !== IDLE) begin errors++; $display("[TB] FAIL en_low_idle got=%h want=%h", outs(), IDLE); end
  endtask

  task automatic test_row0_fetch();
    logic [16:0] ea;
    logic [7:0]  er;
    exp_q.delete();
    en_rise();
    for (int k = 1; k <= 9; k++) begin
      to_tick(k);
      if (k <= 8) begin
        ea = 17'((k - 1) >> 1);
        checks++;
        if (vgactl_addr !== ea) begin errors++; $display("[TB] FAIL row0_addr[%0d] got=%0d want=%0d", k, vgactl_addr, ea); end
        exp_q.push_back(gmem(ea));
      end
      if (k >= 2) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL row0_scoreboard_empty got=0 want=1");
        end else begin
          er = exp_q.pop_front();
          if (vga_rgb !== er || vga_de !== 1'b1) begin
            errors++; $display("[TB] FAIL row0_rgb[%0d] got=%h/de%b want=%h/de1", k, vga_rgb, vga_de, er);
          end
        end
      end
    end
  endtask

  task automatic test_row_mapping();
    en_rise();
    to_tick(640);
    checks++;
    if (vgactl_addr !== 17'd319) begin errors++; $display("[TB] FAIL h639_addr got=%0d want=319", vgactl_addr); end
    to_tick(641);
    checks++;
    if (vgactl_addr !== 17'd0 || vga_de !== 1'b1) begin errors++; $display("[TB] FAIL h640_addr got=%0d/de%b want=0/de1", vgactl_addr, vga_de); end
    to_tick(642);
    checks++;
    if (vga_de !== 1'b0 || vga_rgb !== 8'd0) begin errors++; $display("[TB] FAIL h640_blank got=de%b/%h want=de0/00", vga_de, vga_rgb); end
    to_tick(801);
    checks++;
    if (vgactl_addr !== 17'd0) begin errors++; $display("[TB] FAIL line1_start got=%0d want=0", vgactl_addr); end
    to_tick(803);
    checks++;
    if (vgactl_addr !== 17'd1) begin errors++; $display("[TB] FAIL line1_h2 got=%0d want=1", vgactl_addr); end
    to_tick(1601);
    checks++;
    if (vgactl_addr !== 17'd320) begin errors++; $display("[TB] FAIL line2_start got=%0d want=320", vgactl_addr); end
    to_tick(1603);
    checks++;
    if (vgactl_addr !== 17'd321) begin errors++; $display("[TB] FAIL line2_h2 got=%0d want=321", vgactl_addr); end
  endtask

  task automatic test_reset_midline();
    int first;
    en_rise();
    to_tick(50);
    checks++;
    if (vga_de !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_de got=%b want=1", vga_de); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outs() !== IDLE) begin errors++; $display("[TB] FAIL async_reset got=%h want=%h", outs(), IDLE); end
    @(negedge clk) rst = 1'b1;
    first = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (vga_de && first == 0) first = e;
    end
    checks++;
    if (first != 2 * CLK_DIV) begin errors++; $display("[TB] FAIL reset_restart_de_edge got=%0d want=%0d", first, 2 * CLK_DIV); end
  endtask

  task automatic test_hsync();
    int f1, r1, f2;
    logic prev;
    f1 = 0; r1 = 0; f2 = 0;
    en_rise();
    prev = vga_hs;
    for (int e = 2; e <= 7000; e++) begin
      to_edge(e);
      if (prev && !vga_hs) begin
        if (f1 == 0) f1 = e; else if (f2 == 0) f2 = e;
      end
      if (!prev && vga_hs && r1 == 0) r1 = e;
      prev = vga_hs;
    end
    checks++;
    if (f1 != 2632) begin errors++; $display("[TB] FAIL hs_first_fall got=%0d want=2632", f1); end
    checks++;
    if (r1 - f1 != 384) begin errors++; $display("[TB] FAIL hs_low_width got=%0d want=384", r1 - f1); end
    checks++;
    if (f2 - f1 != 3200) begin errors++; $display("[TB] FAIL hs_period got=%0d want=3200", f2 - f1); end
  endtask

  task automatic test_vsync();
    int fall, rise;
    logic prev;
    fall = 0; rise = 0;
    start_at(10'd700, 10'd489, 17'd0);
    prev = vga_vs;
    for (int e = 2; e <= 7000; e++) begin
      to_edge(e);
      if (prev && !vga_vs && fall == 0) fall = e;
      if (!prev && vga_vs && rise == 0) rise = e;
      prev = vga_vs;
    end
    checks++;
    if (fall != 408) begin errors++; $display("[TB] FAIL vs_fall got=%0d want=408", fall); end
    checks++;
    if (rise - fall != 6400) begin errors++; $display("[TB] FAIL vs_low_width got=%0d want=6400", rise - fall); end
  endtask

  task automatic test_last_pixel_irq();
    int cnt, at;
    start_at(10'd630, 10'd479, 17'd76480);
    to_tick(1);
    checks++;
    if (vgactl_addr !== 17'd76795) begin errors++; $display("[TB] FAIL l479_h630 got=%0d want=76795", vgactl_addr); end
    to_tick(10);
    checks++;
    if (vgactl_addr !== 17'd76799) begin errors++; $display("[TB] FAIL l479_h639 got=%0d want=76799", vgactl_addr); end
    to_tick(11);
    checks++;
    if (vgactl_addr !== 17'd0 || vga_de !== 1'b1) begin errors++; $display("[TB] FAIL l479_h640 got=%0d/de%b want=0/de1", vgactl_addr, vga_de); end
    to_tick(12);
    checks++;
    if (vga_de !== 1'b0) begin errors++; $display("[TB] FAIL l479_blank_de got=%b want=0", vga_de); end
    cnt = 0; at = 0;
    for (int e = edges + 1; e <= 900; e++) begin
      to_edge(e);
      if (frame_irq) begin cnt++; at = e; end
    end
    checks++;
    if (cnt != 1) begin errors++; $display("[TB] FAIL irq_count got=%0d want=1", cnt); end
    checks++;
    if (at != 680) begin errors++; $display("[TB] FAIL irq_edge got=%0d want=680", at); end
  endtask

  task automatic test_irq_en_low();
    int cnt;
    start_at(10'd630, 10'd479, 17'd76480);
    to_edge(600);
    @(negedge clk) en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (frame_irq) cnt++;
    end
    checks++;
    if (cnt != 0) begin errors++; $display("[TB] FAIL irq_en_low got=%0d want=0", cnt); end
  endtask

  task automatic test_en_drop();
    start_at(10'd90, 10'd50, 17'd8000);
    to_tick(10);
    checks++;
    if (vgactl_addr !== 17'd8049 || vga_de !== 1'b1) begin errors++; $display("[TB] FAIL pre_drop got=%0d/de%b want=8049/de1", vgactl_addr, vga_de); end
    @(negedge clk) en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (outs() !== IDLE) begin errors++; $display("[TB] FAIL en_drop_idle got=%h want=%h", outs(), IDLE); end
    en_rise();
    to_tick(1);
    checks++;
    if (vgactl_addr !== 17'd0) begin errors++; $display("[TB] FAIL rerise_addr got=%0d want=0", vgactl_addr); end
    to_tick(2);
    checks++;
    if (vga_de !== 1'b1 || vga_rgb !== gmem(17'd0)) begin errors++; $display("[TB] FAIL rerise_pix got=%h/de%b want=%h/de1", vga_rgb, vga_de, gmem(17'd0)); end
    to_tick(3);
    checks++;
    if (vgactl_addr !== 17'd1) begin errors++; $display("[TB] FAIL rerise_h2 got=%0d want=1", vgactl_addr); end
  endtask

  initial begin
    #(3_000_000);
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_row0_fetch();
    test_row_mapping();
    test_reset_midline();
    test_hsync();
    test_vsync();
    test_last_pixel_irq();
    test_irq_en_low();
    test_en_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vgactl.md
VGACTL -- requirements
Module: vgactl

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per pixel; legal values are 3 or more.
REQ-002 Parameter RD_LAT, default 2, clk cycles from vgactl_addr change to valid vgactl_dat; RD_LAT SHALL be less than CLK_DIV.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  display enable, level-sensitive.
REQ-006 vgactl_addr  output  17  gmem read address for the video port.
REQ-007 vgactl_dat  input  8  gmem read data, one RGB332 pixel.
REQ-008 vga_rgb  output  8  pixel colour, R[7:5] G[4:2] B[1:0].
REQ-009 vga_hs  output  1  horizontal sync, active-low.
REQ-010 vga_vs  output  1  vertical sync, active-low.
REQ-011 vga_de  output  1  high during the visible area.
REQ-012 frame_irq  output  1  one-clk pulse at the start of vertical blanking.

Function
REQ-013 A divider counts 0..CLK_DIV-1; the pixel tick SHALL be high on the clk where the count equals CLK_DIV-1.
REQ-014 Counters hcnt 0..799 and vcnt 0..524 SHALL advance only on a tick.
- hcnt wraps 799->0 and then increments vcnt.
- vcnt wraps 524->0.
REQ-015 The H timing SHALL be: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-016 The V timing SHALL be: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 The framebuffer is 320x240, 2x upscaled: for active (h,v), vgactl_addr SHALL be (v>>1)*320 + (h>>1), registered on the tick.
REQ-018 The address SHALL be formed incrementally with no multiplier.
- A row_base register is added to h>>1.
- row_base += 320 when vcnt leaves an odd line.
- row_base clears to 0 when vcnt wraps.
REQ-019 Outside the active area vgactl_addr SHALL be 0; it SHALL never exceed 76799.
REQ-020 On the tick following an address issue, vga_rgb SHALL capture vgactl_dat.
- vga_hs, vga_vs and vga_de SHALL be delayed by one pixel period so all outputs are aligned to that pixel.
- Total pipeline: one pixel period.
REQ-021 When vga_de is low, vga_rgb SHALL be 0.
REQ-022 frame_irq SHALL pulse for exactly one clk on the tick where vcnt goes 479->480, only when en=1.
REQ-023 While en=0, the block SHALL hold its idle state:
- divider, hcnt, vcnt and row_base cleared;
- vga_rgb = 0, vga_de = 0, vga_hs = 1, vga_vs = 1, vgactl_addr = 0.
REQ-024 When en rises, timing SHALL start at (h=0, v=0) and the first tick SHALL occur CLK_DIV clks later.
REQ-025 An en drop mid-frame SHALL take effect on the next clk with no partial-pixel output.

Reset
REQ-026 On rst=0 all registers SHALL clear asynchronously, with outputs at the idle values of REQ-023 and frame_irq = 0.
REQ-027 On rst release the block SHALL behave as the en-rise case if en=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame; the next frame SHALL restart at (0,0).

Structure
REQ-029 The H/V timing constants, the 320x240 framebuffer geometry and the RGB332 field positions SHALL live in the shared perf constants header, alongside GMEM_WIDTH and COLOR_WIDTH.
REQ-030 The counters and sync decode SHALL sit in one sub-module, vga_timing.
- It outputs tick, hcnt, vcnt, active, hs and vs.
- vgactl adds address generation and the output pipeline.

Verification
REQ-031 Reset check: assert rst mid-line -> all outputs are idle values immediately, without waiting for a clk edge; after release with en=1, the first tick is 4 clks later.
REQ-032 Row 0 fetch: vgactl_addr sequence over the first 8 ticks is 0,0,1,1,2,2,3,3; the vga_rgb of each pixel equals the model gmem contents one tick later.
REQ-033 Row mapping:
- line 1 starts at addr 0;
- line 2 starts at 320;
- line 479, hcnt 639 gives 76799;
- hcnt 640 gives addr 0 and vga_de = 0 one tick later.
REQ-034 Sync timing with CLK_DIV=4:
- vga_hs low for 384 clks;
- hs period 3200 clks;
- vga_vs low for 2 lines (6400 clks).
REQ-035 frame_irq: exactly one 1-clk pulse every 1,680,000 clks with en=1; no pulse while en=0.
REQ-036 en drop at hcnt=100, vcnt=50: next clk shows idle outputs; en re-raised -> addr 0 at (0,0) and a full frame follows.
